// File: rtl/pmu_sleep_ctrl.sv
// rtl/pmu_sleep_ctrl.sv - HF clock sleep/wake sequencer on the always-on clock.
// One shared down-counter times WARM, DRAIN and OFF; wake requests use fixed priority, bit 0 first.
module pmu_sleep_ctrl #(
  parameter int STARTUP_CYCLES = 8,
  parameter int DRAIN_CYCLES   = 4,
  parameter int MIN_OFF_CYCLES = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       sleep_req,
  input  logic [3:0] wake_req,
  output logic       clkhf_powerup,
  output logic       clkhf_enable,
  output logic       cpu_stall,
  output logic       hf_ready,
  output logic [3:0] wake_grant,
  output logic [1:0] wake_cause,
  output logic [7:0] sleep_count,
  output logic [2:0] state_o
);

  localparam logic [2:0] S_BOOT  = 3'd0;
  localparam logic [2:0] S_WARM  = 3'd1;
  localparam logic [2:0] S_RUN   = 3'd2;
  localparam logic [2:0] S_DRAIN = 3'd3;
  localparam logic [2:0] S_GATE  = 3'd4;
  localparam logic [2:0] S_OFF   = 3'd5;

  localparam logic [7:0] L_WARM  = 8'(STARTUP_CYCLES - 1);
  localparam logic [7:0] L_DRAIN = 8'(DRAIN_CYCLES - 1);
  localparam logic [7:0] L_OFF   = 8'(MIN_OFF_CYCLES - 1);

  logic [2:0] r_state;
  logic [2:0] w_state_nxt;
  logic [7:0] r_cnt;
  logic [1:0] r_winner;
  logic       r_wake_pend;
  logic [3:0] r_wake_grant;
  logic [1:0] r_wake_cause;
  logic [7:0] r_sleep_count;
  logic       w_any_wake;
  logic       w_cnt_zero;
  logic [1:0] w_win;

  assign w_any_wake = |wake_req;
  assign w_cnt_zero = (r_cnt == 8'd0);

  always_comb begin
    w_win = 2'd0;
    if (wake_req[0])      w_win = 2'd0;
    else if (wake_req[1]) w_win = 2'd1;
    else if (wake_req[2]) w_win = 2'd2;
    else if (wake_req[3]) w_win = 2'd3;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_BOOT;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_BOOT:  w_state_nxt = S_WARM;
      S_WARM:  if (w_cnt_zero) w_state_nxt = S_RUN;
      S_RUN:   if (sleep_req && !w_any_wake) w_state_nxt = S_DRAIN;
      // a wake during drain cancels the sleep before the clock is gated
      S_DRAIN: begin
        if (w_any_wake)      w_state_nxt = S_RUN;
        else if (w_cnt_zero) w_state_nxt = S_GATE;
      end
      S_GATE:  w_state_nxt = S_OFF;
      S_OFF:   if (w_cnt_zero && w_any_wake) w_state_nxt = S_WARM;
      default: w_state_nxt = S_BOOT;
    endcase
  end

  always_comb begin
    clkhf_powerup = 1'b0;
    clkhf_enable  = 1'b0;
    cpu_stall     = 1'b1;
    hf_ready      = 1'b0;
    case (r_state)
      S_WARM:  clkhf_powerup = 1'b1;
      S_RUN: begin
        clkhf_powerup = 1'b1;
        clkhf_enable  = 1'b1;
        cpu_stall     = 1'b0;
        hf_ready      = 1'b1;
      end
      S_DRAIN: begin
        clkhf_powerup = 1'b1;
        clkhf_enable  = 1'b1;
      end
      S_GATE:  clkhf_powerup = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt         <= 8'd0;
      r_winner      <= 2'd0;
      r_wake_pend   <= 1'b0;
      r_wake_grant  <= 4'd0;
      r_wake_cause  <= 2'd0;
      r_sleep_count <= 8'd0;
    end else begin
      r_wake_grant <= 4'd0;

      if (w_state_nxt != r_state && w_state_nxt == S_WARM)       r_cnt <= L_WARM;
      else if (w_state_nxt != r_state && w_state_nxt == S_DRAIN) r_cnt <= L_DRAIN;
      else if (w_state_nxt != r_state && w_state_nxt == S_OFF)   r_cnt <= L_OFF;
      else if (!w_cnt_zero)                                      r_cnt <= r_cnt - 8'd1;

      if (r_state == S_BOOT) r_wake_pend <= 1'b0;

      // the winner is captured when leaving OFF and reported once the clock is settled
      if (r_state == S_OFF && w_state_nxt == S_WARM) begin
        r_winner    <= w_win;
        r_wake_pend <= 1'b1;
      end

      if (r_state == S_WARM && w_state_nxt == S_RUN && r_wake_pend) begin
        r_wake_grant <= 4'b0001 << r_winner;
        r_wake_cause <= r_winner;
        r_wake_pend  <= 1'b0;
      end

      if (r_state == S_DRAIN && w_state_nxt == S_RUN) begin
        r_wake_grant <= 4'b0001 << w_win;
        r_wake_cause <= w_win;
      end

      if (r_state == S_DRAIN && w_state_nxt == S_GATE && r_sleep_count != 8'hFF)
        r_sleep_count <= r_sleep_count + 8'd1;
    end
  end

  assign wake_grant  = r_wake_grant;
  assign wake_cause  = r_wake_cause;
  assign sleep_count = r_sleep_count;
  assign state_o     = r_state;

endmodule

// File: tb/tb_pmu_sleep_ctrl.sv
// tb/tb_pmu_sleep_ctrl.sv - self-checking bench for pmu_sleep_ctrl.
// Expected grants are queued when a wake is driven and checked when the DUT pulses wake_grant.
module tb_pmu_sleep_ctrl;

  localparam int STARTUP = 8;
  localparam int DRAIN   = 4;
  localparam int MIN_OFF = 2;

  localparam logic [2:0] S_BOOT  = 3'd0;
  localparam logic [2:0] S_WARM  = 3'd1;
  localparam logic [2:0] S_RUN   = 3'd2;
  localparam logic [2:0] S_DRAIN = 3'd3;
  localparam logic [2:0] S_GATE  = 3'd4;
  localparam logic [2:0] S_OFF   = 3'd5;

  logic       clk = 1'b0;
  logic       rst;
  logic       sleep_req;
  logic [3:0] wake_req;
  logic       clkhf_powerup;
  logic       clkhf_enable;
  logic       cpu_stall;
  logic       hf_ready;
  logic [3:0] wake_grant;
  logic [1:0] wake_cause;
  logic [7:0] sleep_count;
  logic [2:0] state_o;

  typedef struct packed {
    logic [3:0] g;
    logic [1:0] c;
    logic [7:0] n;
  } exp_t;

  exp_t       q[$];
  exp_t       mon_e;
  int         n_vec = 0;
  int         n_err = 0;
  int         exp_cnt = 0;
  int         n_len;
  logic [2:0] st[1:9];
  logic       en[1:9];
  logic [3:0] w_rand;

  pmu_sleep_ctrl #(
    .STARTUP_CYCLES(STARTUP),
    .DRAIN_CYCLES  (DRAIN),
    .MIN_OFF_CYCLES(MIN_OFF)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .sleep_req    (sleep_req),
    .wake_req     (wake_req),
    .clkhf_powerup(clkhf_powerup),
    .clkhf_enable (clkhf_enable),
    .cpu_stall    (cpu_stall),
    .hf_ready     (hf_ready),
    .wake_grant   (wake_grant),
    .wake_cause   (wake_cause),
    .sleep_count  (sleep_count),
    .state_o      (state_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [1:0] lowest(input logic [3:0] w);
    lowest = 2'd0;
    for (int i = 3; i >= 0; i--)
      if (w[i]) lowest = 2'(i);
  endfunction

  task automatic run_len(input logic [2:0] s, output int n);
    n = 0;
    while (state_o == s && n < 400) begin
      n++;
      @(negedge clk);
    end
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_state"},   32'(state_o),       32'(S_BOOT));
    chk({tag, "_powerup"}, 32'(clkhf_powerup), 32'd0);
    chk({tag, "_enable"},  32'(clkhf_enable),  32'd0);
    chk({tag, "_stall"},   32'(cpu_stall),     32'd1);
    chk({tag, "_ready"},   32'(hf_ready),      32'd0);
    chk({tag, "_grant"},   32'(wake_grant),    32'd0);
    chk({tag, "_cause"},   32'(wake_cause),    32'd0);
    chk({tag, "_count"},   32'(sleep_count),   32'd0);
  endtask

  task automatic sleep_cycle(input logic [3:0] w, input int off_wait);
    int n;
    int n_off;
    int e_off;
    sleep_req = 1'b1;
    @(negedge clk);
    sleep_req = 1'b0;
    chk("enter_drain", 32'(state_o), 32'(S_DRAIN));
    run_len(S_DRAIN, n);
    chk("drain_len", 32'(n), 32'(DRAIN));
    exp_cnt = (exp_cnt == 255) ? 255 : exp_cnt + 1;
    chk("gate_state", 32'(state_o), 32'(S_GATE));
    chk("gate_count", 32'(sleep_count), 32'(exp_cnt));
    chk("gate_enable", 32'(clkhf_enable), 32'd0);
    run_len(S_GATE, n);
    chk("gate_len", 32'(n), 32'd1);
    chk("off_state", 32'(state_o), 32'(S_OFF));
    chk("off_powerup", 32'(clkhf_powerup), 32'd0);
    n_off = 0;
    repeat (off_wait) begin
      n_off++;
      @(negedge clk);
    end
    wake_req = w;
    q.push_back('{g: 4'b0001 << lowest(w), c: lowest(w), n: 8'(exp_cnt)});
    run_len(S_OFF, n);
    n_off += n;
    wake_req = 4'd0;
    e_off = (off_wait + 1 > MIN_OFF) ? off_wait + 1 : MIN_OFF;
    chk("off_len", 32'(n_off), 32'(e_off));
    run_len(S_WARM, n);
    chk("warm_len", 32'(n), 32'(STARTUP));
    chk("run_state", 32'(state_o), 32'(S_RUN));
  endtask

  always @(negedge clk) begin
    if (!rst && wake_grant != 4'd0) begin
      if (q.size() == 0) begin
        chk("spurious_grant", 32'(wake_grant), 32'd0);
      end else begin
        mon_e = q.pop_front();
        chk("wake_grant", 32'(wake_grant), 32'(mon_e.g));
        chk("wake_cause", 32'(wake_cause), 32'(mon_e.c));
        chk("grant_count", 32'(sleep_count), 32'(mon_e.n));
        chk("grant_ready", 32'(hf_ready), 32'd1);
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    sleep_req = 1'b0;
    wake_req = 4'd0;
    @(negedge clk);
    chk_reset_outputs("reset");

    rst = 1'b0;
    for (int i = 1; i <= 9; i++) begin
      @(negedge clk);
      st[i] = state_o;
      en[i] = clkhf_enable;
    end
    chk("boot_to_warm", 32'(st[1]), 32'(S_WARM));
    chk("warm_last", 32'(st[8]), 32'(S_WARM));
    chk("warm_enable", 32'(en[8]), 32'd0);
    chk("first_run", 32'(st[9]), 32'(S_RUN));
    chk("first_enable", 32'(en[9]), 32'd1);
    chk("run_stall", 32'(cpu_stall), 32'd0);
    chk("run_ready", 32'(hf_ready), 32'd1);

    sleep_cycle(4'b0110, 3);

    sleep_req = 1'b1;
    @(negedge clk);
    sleep_req = 1'b0;
    chk("abort_drain1", 32'(state_o), 32'(S_DRAIN));
    @(negedge clk);
    chk("abort_drain2", 32'(state_o), 32'(S_DRAIN));
    wake_req = 4'b1000;
    q.push_back('{g: 4'b1000, c: 2'd3, n: 8'(exp_cnt)});
    @(negedge clk);
    wake_req = 4'd0;
    chk("abort_run", 32'(state_o), 32'(S_RUN));
    chk("abort_count", 32'(sleep_count), 32'(exp_cnt));

    sleep_req = 1'b1;
    wake_req = 4'b0001;
    @(negedge clk);
    sleep_req = 1'b0;
    wake_req = 4'd0;
    for (int i = 0; i < 3; i++) begin
      chk("wake_wins_run", 32'(state_o), 32'(S_RUN));
      @(negedge clk);
    end

    sleep_cycle(4'b0100, 0);

    sleep_req = 1'b1;
    @(negedge clk);
    sleep_req = 1'b0;
    run_len(S_DRAIN, n_len);
    exp_cnt = exp_cnt + 1;
    run_len(S_GATE, n_len);
    chk("lost_off_entry", 32'(state_o), 32'(S_OFF));
    wake_req = 4'b0001;
    @(negedge clk);
    wake_req = 4'd0;
    repeat (20) @(negedge clk);
    chk("lost_wake_off", 32'(state_o), 32'(S_OFF));
    wake_req = 4'b0001;
    q.push_back('{g: 4'b0001, c: 2'd0, n: 8'(exp_cnt)});
    run_len(S_OFF, n_len);
    wake_req = 4'd0;
    run_len(S_WARM, n_len);
    chk("lost_warm_len", 32'(n_len), 32'(STARTUP));
    chk("lost_run", 32'(state_o), 32'(S_RUN));

    for (int i = 0; i < 256; i++) begin
      w_rand = 4'($urandom_range(1, 15));
      sleep_cycle(w_rand, i % 4);
    end
    chk("count_saturated", 32'(sleep_count), 32'd255);

    sleep_req = 1'b1;
    @(negedge clk);
    sleep_req = 1'b0;
    run_len(S_DRAIN, n_len);
    run_len(S_GATE, n_len);
    wake_req = 4'b0010;
    run_len(S_OFF, n_len);
    wake_req = 4'd0;
    repeat (3) @(negedge clk);
    chk("mid_warm", 32'(state_o), 32'(S_WARM));
    #2 rst = 1'b1;
    #1 chk_reset_outputs("warm_rst");
    exp_cnt = 0;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("restart_warm", 32'(state_o), 32'(S_WARM));
    repeat (STARTUP) @(negedge clk);
    chk("restart_run", 32'(state_o), 32'(S_RUN));

    sleep_req = 1'b1;
    @(negedge clk);
    sleep_req = 1'b0;
    @(negedge clk);
    chk("mid_drain", 32'(state_o), 32'(S_DRAIN));
    #2 rst = 1'b1;
    #1 chk_reset_outputs("drain_rst");
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("restart2_warm", 32'(state_o), 32'(S_WARM));

    chk("grants_pending", 32'(q.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
